mp_add_seq: RTL and testbench
=============================

Name: mp_add_seq

Overview:
- Multi-word add/subtract sequencer. Performs WORDS*W-bit operations (e.g. KL10 double-word 72-bit add) by running one shared W-bit carry-lookahead word adder once per cycle, least-significant word first.
- Carries the inter-word carry in a register between cycles.
- Sits between the EBOX microcode request interface and the word adder.
- Returns the sum plus carry-out, overflow and zero flags over a valid/ready handshake.

Parameters:
- W, 36, width of one word and of the shared adder
- WORDS, 2, number of words per operand (>=1)

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_sub  in  1  1 = A minus B, 0 = A plus B
- req_a  in  WORDS*W  operand A, [0:WORDS*W-1], bit 0 MSB
- req_b  in  WORDS*W  operand B, same layout
- flush  in  1  synchronous abort
- res_valid  out  1  result present
- res_ready  in  1  consumer takes result
- res_sum  out  WORDS*W  result, same layout
- res_cout  out  1  carry out of bit 0 (subtract: 1 = no borrow)
- res_ovf  out  1  two's-complement overflow
- res_zero  out  1  res_sum all zero

Behaviour:
- Word layout: word k occupies bits [k*W : k*W+W-1]. Word 0 is most significant. Processing order is WORDS-1 down to 0.
- States:
  - IDLE: req_ready=1.
  - RUN: req_ready=0, res_valid=0.
  - DONE: res_valid=1, req_ready=0.
- Accept: req_valid & req_ready at an edge.
  - Latch A.
  - Latch B, or ~B when req_sub=1.
  - cnt <= WORDS-1; carry <= req_sub.
  - Go to RUN.
- RUN, each edge:
  - Word cnt = A_word + B_word + carry.
  - Store the sum word into result word cnt; carry <= word cout.
  - If cnt==0: capture res_cout, res_ovf and res_zero, then go to DONE. Otherwise cnt <= cnt-1.
- Latency: res_valid rises exactly WORDS edges after the accepting edge. Throughput is one op per WORDS+2 cycles minimum (no accept in DONE).
- res_ovf = (A[0] == B'[0]) & (sum[0] != A[0]), where B' is the possibly inverted B.
- res_zero = NOR of all result bits, evaluated with the final word included.
- DONE: outputs held stable until res_valid & res_ready at an edge, then go to IDLE. res_sum, res_cout, res_ovf and res_zero stay unchanged until the next completion.
- flush = 1 at an edge: go to IDLE from any state and drop any pending result (res_valid=0). Flush has priority over accept and over the result handshake. Registered result data is not cleared.
- Reset (async, any time including mid-RUN):
  - State=IDLE, cnt=0, carry=0.
  - res_sum=0, res_cout=0, res_ovf=0, res_zero=0.
  - res_valid=0; req_ready=1 once rst_n deasserts.
- WORDS=1: RUN lasts exactly one cycle.
- req_a and req_b are don't-care outside the accepting edge.

Decomposition:
- Package mp_add_pkg:
  - state enum {IDLE, RUN, DONE}
  - cnt width constant $clog2(WORDS) (minimum 1)
  - word-slice helper function
- Sub-module mp_add_word: combinational W-bit adder (a, b, cin -> sum, cout). Built from 4-bit group generate/propagate with lookahead carry, matching the codebase's ECL-derived adder structure.

Test Plan:
- W=36, WORDS=2, add: A=1, B=1 -> res_sum=2, cout=0, ovf=0, zero=0; res_valid exactly 2 edges after accept.
- Inter-word carry: A={0, 36'o777777777777}, B={0, 1} -> res_sum={1, 0}, cout=0, ovf=0.
- Subtract, borrow: A=0, B=1, sub=1 -> res_sum all ones, cout=0, ovf=0. Also A=B=5, sub=1 -> sum 0, zero=1, cout=1.
- Overflow: A={36'o377777777777, 36'o777777777777}, B=1 -> res_sum={36'o400000000000, 0}, ovf=1, cout=0.
- Backpressure: res_ready=0 for 5 cycles -> res_valid and res_sum stable and req_ready=0 throughout; on res_ready=1, IDLE and req_ready=1 next cycle.
- Flush and reset:
  - flush in RUN -> IDLE, no res_valid, and the next op is correct.
  - rst_n low mid-RUN -> all outputs 0 immediately (asynchronous), req_ready=1 after release.

Source files
------------

// File: rtl/mp_add_pkg.sv
// Shared types and helpers for the multi-word add/subtract sequencer.
package mp_add_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Word counter width; a single-word configuration still gets one bit.
  function automatic int cnt_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  // First (most significant) bit index of word k in a bit-0-MSB vector.
  function automatic int word_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/mp_add_seq_if.sv
// Request/result handshake bundle between the microcode side and the sequencer.
interface mp_add_seq_if #(
  parameter int W     = 36,
  parameter int WORDS = 2
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_sub;
  logic [0:W*WORDS-1]   req_a;
  logic [0:W*WORDS-1]   req_b;
  logic                 flush;
  logic                 res_valid;
  logic                 res_ready;
  logic [0:W*WORDS-1]   res_sum;
  logic                 res_cout;
  logic                 res_ovf;
  logic                 res_zero;

  modport master (
    output req_valid, req_sub, req_a, req_b, flush, res_ready,
    input  req_ready, res_valid, res_sum, res_cout, res_ovf, res_zero
  );

  modport slave (
    input  req_valid, req_sub, req_a, req_b, flush, res_ready,
    output req_ready, res_valid, res_sum, res_cout, res_ovf, res_zero
  );
endinterface

// File: rtl/mp_add_word.sv
// Combinational W-bit adder: 4-bit group generate/propagate with lookahead carries.
module mp_add_word #(
  parameter int W = 36
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  localparam int NG = (W + 3) / 4;
  localparam int WP = NG * 4;

  logic [WP-1:0] ap, bp, p, g, s;
  logic [WP:0]   c;
  logic [NG-1:0] gg, gp;
  logic [NG:0]   gc;

  assign ap = WP'(a);
  assign bp = WP'(b);
  assign p  = ap ^ bp;
  assign g  = ap & bp;
  assign gc[0] = cin;

  // Padding bits above W have p=g=0, so they never disturb the real carry.
  for (genvar i = 0; i < NG; i++) begin : grp
    localparam int B = 4 * i;
    assign gp[i]    = &p[B +: 4];
    assign gg[i]    = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                    | (p[B+3] & p[B+2] & p[B+1] & g[B]);
    assign gc[i+1]  = gg[i] | (gp[i] & gc[i]);
    assign c[B]     = gc[i];
    assign c[B+1]   = g[B] | (p[B] & gc[i]);
    assign c[B+2]   = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[i]);
    assign c[B+3]   = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                    | (p[B+2] & p[B+1] & p[B] & gc[i]);
  end

  assign c[WP] = gc[NG];
  assign s     = p ^ c[WP-1:0];
  assign sum   = s[W-1:0];
  assign cout  = c[W];
endmodule

// File: rtl/mp_add_seq.sv
// Multi-word add/subtract: one shared word adder, least-significant word first.
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int W     = 36,
  parameter int WORDS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  mp_add_seq_if.slave bus
);
  localparam int N  = W * WORDS;
  localparam int CW = cnt_width(WORDS);

  state_e        state, state_nx;
  logic [CW-1:0] cnt;
  logic          carry;
  logic [0:N-1]  a_q, b_q, work_q, res_q, merged;
  logic          cout_q, ovf_q, zero_q;
  logic [W-1:0]  wa, wb, ws;
  logic          wc;
  logic          accept, last;
  int            lo;

  assign lo     = word_lo(int'(cnt), W);
  assign wa     = a_q[lo +: W];
  assign wb     = b_q[lo +: W];
  assign last   = (cnt == '0);
  assign accept = (state == IDLE) && bus.req_valid && !bus.flush;

  mp_add_word #(.W(W)) u_word (
    .a    (wa),
    .b    (wb),
    .cin  (carry),
    .sum  (ws),
    .cout (wc)
  );

  // Full result including the word being produced this cycle.
  always_comb begin
    merged          = work_q;
    merged[lo +: W] = ws;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nx = RUN;
      RUN:     if (last)          state_nx = DONE;
      DONE:    if (bus.res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (bus.flush) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      work_q <= '0;
      res_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_q   <= bus.req_a;
        b_q   <= bus.req_sub ? ~bus.req_b : bus.req_b;
        cnt   <= CW'(WORDS - 1);
        carry <= bus.req_sub;
      end else if (state == RUN && !bus.flush) begin
        work_q[lo +: W] <= ws;
        carry           <= wc;
        // Published result only changes on completion, never mid-run.
        if (last) begin
          res_q  <= merged;
          cout_q <= wc;
          ovf_q  <= (a_q[0] == b_q[0]) && (ws[W-1] != a_q[0]);
          zero_q <= ~|merged;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  assign bus.req_ready = (state == IDLE) && rst_n;
  assign bus.res_valid = (state == DONE);
  assign bus.res_sum   = res_q;
  assign bus.res_cout  = cout_q;
  assign bus.res_ovf   = ovf_q;
  assign bus.res_zero  = zero_q;
endmodule

// File: tb/tb_mp_add_seq.sv
// Scoreboard bench for mp_add_seq at W=36, WORDS=2.
module tb_mp_add_seq;
  localparam int W     = 36;
  localparam int WORDS = 2;
  localparam int N     = W * WORDS;

  typedef struct packed {
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  res_t sb_q[$];

  mp_add_seq_if #(.W(W), .WORDS(WORDS)) bus ();

  mp_add_seq #(.W(W), .WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
    logic [N:0]   t;
    logic [N-1:0] bp;
    res_t r;
    bp     = sub ? ~b : b;
    t      = {1'b0, a} + {1'b0, bp} + {{N{1'b0}}, sub};
    r.sum  = t[N-1:0];
    r.cout = t[N];
    r.ovf  = (a[N-1] == bp[N-1]) && (r.sum[N-1] != a[N-1]);
    r.zero = (r.sum == '0);
    return r;
  endfunction

  // Drive one request; returns once the accepting edge has passed (+1).
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub,
                       input logic push);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_sub   = sub;
    if (push) sb_q.push_back(model(a, b, sub));
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
  endtask

  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic sub, input int stall);
    int   edges;
    res_t exp;
    logic [N-1:0] snap;
    bus.res_ready = (stall == 0);
    issue(a, b, sub, 1'b1);
    edges = 0;
    while (!bus.res_valid && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk({tag, ".lat"}, 80'(edges), 80'(WORDS));
    if (sb_q.size() == 0) begin
      chk({tag, ".sb"}, 80'(0), 80'(1));
      return;
    end
    exp = sb_q.pop_front();
    snap = bus.res_sum;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      chk({tag, ".hold_v"}, 80'(bus.res_valid), 80'(1));
      chk({tag, ".hold_s"}, 80'(bus.res_sum), 80'(snap));
      chk({tag, ".hold_rr"}, 80'(bus.req_ready), 80'(0));
    end
    chk({tag, ".sum"}, 80'(bus.res_sum), 80'(exp.sum));
    chk({tag, ".cout"}, 80'(bus.res_cout), 80'(exp.cout));
    chk({tag, ".ovf"}, 80'(bus.res_ovf), 80'(exp.ovf));
    chk({tag, ".zero"}, 80'(bus.res_zero), 80'(exp.zero));
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    if (stall > 0) begin
      chk({tag, ".rel_v"}, 80'(bus.res_valid), 80'(0));
      chk({tag, ".rel_rr"}, 80'(bus.req_ready), 80'(1));
    end
  endtask

  initial begin
    logic [N-1:0] ones36, a, b, prev;
    bus.req_valid = 1'b0;
    bus.req_sub   = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.flush     = 1'b0;
    bus.res_ready = 1'b1;
    ones36 = {{(N-W){1'b0}}, {W{1'b1}}};

    #12;
    chk("rst.sum", 80'(bus.res_sum), 80'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.rr", 80'(bus.req_ready), 80'(1));
    chk("rst.v", 80'(bus.res_valid), 80'(0));
    chk("rst.flags", 80'({bus.res_cout, bus.res_ovf, bus.res_zero}), 80'(0));

    run_op("add11", 72'd1, 72'd1, 1'b0, 0);
    run_op("icarry", ones36, 72'd1, 1'b0, 0);
    run_op("borrow", 72'd0, 72'd1, 1'b1, 0);
    run_op("sub55", 72'd5, 72'd5, 1'b1, 0);
    run_op("ovf", {36'o377777777777, 36'o777777777777}, 72'd1, 1'b0, 0);
    chk("ovf.hand", 80'(bus.res_sum), 80'({36'o400000000000, 36'd0}));
    for (int i = 0; i < 4; i++) begin
      a = {$urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom};
      run_op($sformatf("rnd%0d", i), a, b, 1'($urandom_range(0, 1)), 0);
    end
    run_op("stall", {$urandom, $urandom, $urandom}, 72'd12345, 1'b0, 5);

    // Flush one cycle into RUN: no result, sequencer back to IDLE.
    bus.res_ready = 1'b1;
    issue(72'd7, 72'd9, 1'b0, 1'b0);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("flush.rr", 80'(bus.req_ready), 80'(1));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("flush.nov", 80'(bus.res_valid), 80'(0));
    end
    run_op("postfl", {36'o377777777777, 36'o777777777777}, 72'd1, 1'b0, 0);

    // Async reset mid-RUN after a result with nonzero sum and ovf=1.
    prev = bus.res_sum;
    issue(72'd3, 72'd4, 1'b0, 1'b0);
    chk("midrun.keep", 80'(bus.res_sum), 80'(prev));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.sum", 80'(bus.res_sum), 80'(0));
    chk("arst.flags", 80'({bus.res_cout, bus.res_ovf, bus.res_zero}), 80'(0));
    chk("arst.v", 80'(bus.res_valid), 80'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst.rr", 80'(bus.req_ready), 80'(1));
    run_op("postrst", 72'd100, 72'd58, 1'b1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
